ahb_master_interface: RTL and testbench
=======================================

AHB_MASTER_INTERFACE -- requirements
Module: ahb_master_interface

Interface
REQ-001 SHALL have port HCLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port HRESETn, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port cmd_valid, input, 1 bit: a transfer request is present.
REQ-004 SHALL have port cmd_ready, output, 1 bit: the request is accepted when cmd_valid && cmd_ready.
REQ-005 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port cmd_addr, input, 32 bits: start byte address.
REQ-007 SHALL have port cmd_burst, input, 2 bits: 00 SINGLE, 01 INCR4, 10 INCR8, 11 treated as SINGLE.
REQ-008 SHALL have port wd_valid, input, 1 bit: write word available.
REQ-009 SHALL have port wd_data, input, 32 bits: write word.
REQ-010 SHALL have port wd_ready, output, 1 bit: write word consumed this cycle.
REQ-011 SHALL have port rd_valid, output, 1 bit: read word valid this cycle.
REQ-012 SHALL have port rd_data, output, 32 bits: read word.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at end of command.
REQ-014 SHALL have port err, output, 1 bit: qualifies done; 1 = command terminated by an error response.
REQ-015 SHALL have ports Haddr (32 bits), Htrans (2 bits), Hwrite (1 bit), Hsize (3 bits), Hburst (3 bits) and Hwdata (32 bits), all outputs: AHB address and control.
REQ-016 SHALL have ports Hrdata (32 bits), Hreadyout (1 bit) and Hresp (2 bits), all inputs: AHB slave response.

Function
REQ-017 SHALL drive Hsize as 3'b010 (word); SHALL force Haddr[1:0] = 00.
REQ-018 SHALL map Hburst as SINGLE 000, INCR4 011, INCR8 101; beat count 1/4/8.
REQ-019 SHALL encode Htrans as IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-020 SHALL use FSM states IDLE, ADDR, BUSYW, LAST, ERR.
REQ-021 SHALL assert cmd_ready only in IDLE; for a write, only while wd_valid = 1.
REQ-022 On acceptance at edge N, SHALL in cycle N+1 drive Htrans = NONSEQ, Haddr, Hwrite and Hburst, and pulse wd_ready if writing, then enter ADDR.
REQ-023 SHALL treat an address phase as complete at an edge where Hreadyout = 1; SHALL hold all address/control while Hreadyout = 0.
REQ-024 On each completed non-final beat, SHALL present the next beat at Haddr + 4 with Htrans = SEQ.
REQ-025 SHALL issue a next beat whose Haddr[9:0] = 0 as NONSEQ instead of SEQ (1 KB boundary).
REQ-026 For a write, if wd_valid = 0 when the next beat is due, SHALL enter BUSYW and drive Htrans = BUSY with the next beat's address; SHALL drive SEQ the cycle after wd_valid returns.
REQ-027 SHALL assert wd_ready only in a cycle where a write NONSEQ/SEQ is driven and wd_valid = 1; at most 8 wd_ready pulses per command.
REQ-028 SHALL drive Hwdata with the word registered at that beat's address phase, for the whole data phase (held while Hreadyout = 0).
REQ-029 For reads, SHALL assert rd_valid = 1 with rd_data = Hrdata for one cycle at each data-phase edge where Hreadyout = 1 and Hresp = 00.
REQ-030 After the final address phase completes, SHALL drive Htrans = IDLE and wait in LAST for the final data phase.
REQ-031 SHALL pulse done (err = 0) in the cycle after the final data phase completes OKAY; SHALL return to IDLE, and cmd_ready MAY assert in that same cycle.
REQ-032 SHALL treat Hresp != 00 with Hreadyout = 0 (the first error cycle) as an error: drive Htrans = IDLE next cycle, cancel remaining beats, issue no further wd_ready, and enter ERR.
REQ-033 In ERR, SHALL pulse done with err = 1 after the second error cycle (Hreadyout = 1); SHALL give no rd_valid for the errored beat.
REQ-034 SHALL give priority to an error response over any pending BUSY or SEQ in the same cycle.

Reset
REQ-035 While HRESETn = 0 at an edge, SHALL set: state IDLE, Htrans = 00, Haddr = 0, Hwrite = 0, Hburst = 0, Hwdata = 0, cmd_ready = 0, wd_ready = 0, rd_valid = 0, rd_data = 0, done = 0, err = 0.
REQ-036 Reset mid-burst SHALL abandon the burst without a done pulse; SHALL set cmd_ready = 1 in the first cycle after HRESETn = 1.

Verification
REQ-037 SHALL cover: SINGLE read at 0x8000_0010, Hreadyout = 1 -> NONSEQ/addr 0x8000_0010; rd_valid with Hrdata 0xA5A5_0001 next cycle; done, err = 0.
REQ-038 SHALL cover: INCR4 write at 0x8400_0000, data 1..4, no waits -> NONSEQ, SEQ, SEQ, SEQ at +0/+4/+8/+C; Hwdata 1..4 lagging one cycle; 4 wd_ready pulses.
REQ-039 SHALL cover: INCR8 write with wd_valid low for 2 cycles before beat 3 -> 2 BUSY cycles at addr +8, then SEQ; data order intact.
REQ-040 SHALL cover: INCR4 read at 0x8000_03F8 -> beats at 3F8, 3FC, 400 (NONSEQ), 404 (SEQ).
REQ-041 SHALL cover: INCR8 read, ERROR on beat 2 (Hresp = 01: Hreadyout 0 then 1) -> Htrans IDLE next cycle, 1 rd_valid only, done with err = 1.
REQ-042 SHALL cover: HRESETn low during beat 3 of INCR8 -> all outputs at reset values, no done; a new SINGLE command accepted afterwards.

Source files
------------

// File: rtl/ahb_master_interface.sv
// Command-driven AHB-Lite master: SINGLE/INCR4/INCR8 word bursts, first beat on the bus the cycle after accept.
// Write data is pulled one word per beat; a missing word stalls the burst with BUSY. rd_valid/done are registered (one cycle after the data phase).
module ahb_master_interface (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_burst,
    input  logic        wd_valid,
    input  logic [31:0] wd_data,
    output logic        wd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [31:0] Haddr,
    output logic [1:0]  Htrans,
    output logic        Hwrite,
    output logic [2:0]  Hsize,
    output logic [2:0]  Hburst,
    output logic [31:0] Hwdata,
    input  logic [31:0] Hrdata,
    input  logic        Hreadyout,
    input  logic [1:0]  Hresp
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {IDLE, ADDR, BUSYW, LAST, ERR} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [2:0]  r_hburst;
    logic [3:0]  r_beats_left;
    logic [1:0]  r_kind;
    logic        r_taken;
    logic [31:0] r_wbuf;
    logic        r_dp_vld;
    logic        r_dp_write;

    logic        w_in_addr;
    logic        w_have;
    logic        w_err_1st;
    logic        w_dp_done;
    logic        w_dp_ok;
    logic        w_accept;
    logic        w_addr_done;
    logic        w_last_beat;
    logic [31:0] w_addr_nxt;

    assign w_in_addr   = (r_state == ADDR) || (r_state == BUSYW);
    // A read beat can always go; a write beat needs its word, either held or offered now.
    assign w_have      = !r_hwrite || r_taken || wd_valid;
    assign w_err_1st   = r_dp_vld && !Hreadyout && (Hresp != 2'b00);
    assign w_dp_done   = r_dp_vld && Hreadyout;
    assign w_dp_ok     = w_dp_done && (Hresp == 2'b00);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_addr_done = w_in_addr && w_have && Hreadyout;
    assign w_last_beat = (r_beats_left == 4'd1);
    assign w_addr_nxt  = r_haddr + 32'd4;

    assign cmd_ready = HRESETn && (r_state == IDLE) && (!cmd_write || wd_valid);
    assign wd_ready  = w_in_addr && r_hwrite && !r_taken && wd_valid && !w_err_1st;
    assign Htrans    = w_in_addr ? (w_have ? r_kind : HT_BUSY) : HT_IDLE;
    assign Haddr     = r_haddr;
    assign Hwrite    = r_hwrite;
    assign Hburst    = r_hburst;
    assign Hsize     = 3'b010;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = ADDR;
            ADDR, BUSYW: begin
                if (w_err_1st)        w_state_nxt = ERR;
                else if (w_addr_done) w_state_nxt = w_last_beat ? LAST : ADDR;
                else                  w_state_nxt = w_have ? ADDR : BUSYW;
            end
            LAST: begin
                if (w_err_1st)      w_state_nxt = ERR;
                else if (w_dp_done) w_state_nxt = IDLE;
            end
            ERR:   if (Hreadyout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_hburst     <= '0;
            r_beats_left <= '0;
            r_kind       <= HT_NONSEQ;
            r_taken      <= 1'b0;
            r_wbuf       <= '0;
            r_dp_vld     <= 1'b0;
            r_dp_write   <= 1'b0;
            Hwdata       <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (w_dp_ok && !r_dp_write) begin
                rd_valid <= 1'b1;
                rd_data  <= Hrdata;
            end
            if (w_dp_done) r_dp_vld <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_haddr  <= cmd_addr & ~32'h3;
                    r_hwrite <= cmd_write;
                    r_kind   <= HT_NONSEQ;
                    r_taken  <= 1'b0;
                    case (cmd_burst)
                        2'b01:   begin r_hburst <= 3'b011; r_beats_left <= 4'd4; end
                        2'b10:   begin r_hburst <= 3'b101; r_beats_left <= 4'd8; end
                        default: begin r_hburst <= 3'b000; r_beats_left <= 4'd1; end
                    endcase
                end
                ADDR, BUSYW: if (!w_err_1st) begin
                    // A word taken during a waited address phase is parked until the phase completes.
                    if (wd_ready) begin
                        r_taken <= 1'b1;
                        r_wbuf  <= wd_data;
                    end
                    if (w_addr_done) begin
                        r_dp_vld   <= 1'b1;
                        r_dp_write <= r_hwrite;
                        if (r_hwrite) Hwdata <= r_taken ? r_wbuf : wd_data;
                        if (!w_last_beat) begin
                            r_haddr      <= w_addr_nxt;
                            r_kind       <= (w_addr_nxt[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
                            r_beats_left <= r_beats_left - 4'd1;
                            r_taken      <= 1'b0;
                        end
                    end
                end
                LAST: if (w_dp_done) begin
                    done <= 1'b1;
                    err  <= (Hresp != 2'b00);
                end
                ERR: if (Hreadyout) begin
                    done     <= 1'b1;
                    err      <= 1'b1;
                    r_dp_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_interface.sv
// Directed bench for ahb_master_interface: the slave side is driven by hand each cycle, outputs checked on the falling edge.
module tb_ahb_master_interface;

    logic        HCLK, HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_burst;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done, err;
    logic [31:0] Haddr, Hwdata, Hrdata;
    logic [1:0]  Htrans, Hresp;
    logic        Hwrite, Hreadyout;
    logic [2:0]  Hsize, Hburst;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wdr   = 0;
    int wdr_base;

    ahb_master_interface dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Hwdata(Hwdata),
        .Hrdata(Hrdata), .Hreadyout(Hreadyout), .Hresp(Hresp)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) if (wd_ready === 1'b1) n_wdr <= n_wdr + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " Htrans"},    32'(Htrans),    32'd0);
        chk({tag, " Haddr"},     Haddr,          32'd0);
        chk({tag, " Hwrite"},    32'(Hwrite),    32'd0);
        chk({tag, " Hburst"},    32'(Hburst),    32'd0);
        chk({tag, " Hwdata"},    Hwdata,         32'd0);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, " wd_ready"},  32'(wd_ready),  32'd0);
        chk({tag, " rd_valid"},  32'(rd_valid),  32'd0);
        chk({tag, " rd_data"},   rd_data,        32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
        chk({tag, " err"},       32'(err),       32'd0);
    endtask

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_burst = '0;
        wd_valid = 1'b0; wd_data = '0; Hrdata = '0; Hreadyout = 1'b1; Hresp = 2'b00;

        // Reset state
        cyc; cyc;
        @(negedge HCLK);
        chk_reset_vals("rst");
        chk("rst Hsize", 32'(Hsize), 32'd2);

        // SINGLE read at 0x8000_0010
        cyc; HRESETn = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_0010; cmd_burst = 2'b00;
        @(negedge HCLK); chk("single cmd_ready", 32'(cmd_ready), 32'd1);
        cyc; cmd_valid = 1'b0;
        @(negedge HCLK);
        chk("single Htrans", 32'(Htrans), 32'd2);
        chk("single Haddr",  Haddr, 32'h8000_0010);
        chk("single Hburst", 32'(Hburst), 32'd0);
        chk("single Hwrite", 32'(Hwrite), 32'd0);
        chk("single busy cmd_ready", 32'(cmd_ready), 32'd0);
        cyc; Hrdata = 32'hA5A5_0001;
        @(negedge HCLK);
        chk("single last Htrans", 32'(Htrans), 32'd0);
        chk("single early rd_valid", 32'(rd_valid), 32'd0);
        cyc; Hrdata = 32'h0;
        @(negedge HCLK);
        chk("single rd_valid", 32'(rd_valid), 32'd1);
        chk("single rd_data",  rd_data, 32'hA5A5_0001);
        chk("single done", 32'(done), 32'd1);
        chk("single err",  32'(err),  32'd0);
        chk("single ready again", 32'(cmd_ready), 32'd1);
        cyc;
        @(negedge HCLK); chk("single done clears", 32'(done), 32'd0);

        // INCR4 write at 0x8400_0000, data 1..4, no waits
        cyc; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8400_0000; cmd_burst = 2'b01;
        wd_valid = 1'b1; wd_data = 32'd1;
        @(negedge HCLK);
        chk("incr4w cmd_ready", 32'(cmd_ready), 32'd1);
        chk("incr4w idle wd_ready", 32'(wd_ready), 32'd0);
        wdr_base = n_wdr;
        for (int i = 0; i < 4; i++) begin
            cyc; cmd_valid = 1'b0; wd_data = 32'(i + 1);
            @(negedge HCLK);
            chk("incr4w Htrans", 32'(Htrans), (i == 0) ? 32'd2 : 32'd3);
            chk("incr4w Haddr", Haddr, 32'h8400_0000 + 32'(4 * i));
            chk("incr4w wd_ready", 32'(wd_ready), 32'd1);
            if (i == 0) chk("incr4w Hburst", 32'(Hburst), 32'd3);
            else        chk("incr4w Hwdata", Hwdata, 32'(i));
        end
        cyc; wd_valid = 1'b0;
        @(negedge HCLK);
        chk("incr4w last Htrans", 32'(Htrans), 32'd0);
        chk("incr4w last Hwdata", Hwdata, 32'd4);
        chk("incr4w last wd_ready", 32'(wd_ready), 32'd0);
        cyc;
        @(negedge HCLK);
        chk("incr4w done", 32'(done), 32'd1);
        chk("incr4w err",  32'(err),  32'd0);
        cyc;
        chk("incr4w wd_ready pulses", 32'(n_wdr - wdr_base), 32'd4);

        // INCR8 write with wd_valid low for 2 cycles before beat 3
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8400_0100; cmd_burst = 2'b10;
        wd_valid = 1'b1; wd_data = 32'd1;
        @(negedge HCLK); chk("incr8w cmd_ready", 32'(cmd_ready), 32'd1);
        wdr_base = n_wdr;
        for (int i = 0; i < 2; i++) begin
            cyc; cmd_valid = 1'b0; wd_data = 32'(i + 1);
            @(negedge HCLK);
            chk("incr8w Htrans", 32'(Htrans), (i == 0) ? 32'd2 : 32'd3);
            chk("incr8w Haddr", Haddr, 32'h8400_0100 + 32'(4 * i));
            chk("incr8w wd_ready", 32'(wd_ready), 32'd1);
        end
        for (int b = 0; b < 2; b++) begin
            cyc; wd_valid = 1'b0;
            @(negedge HCLK);
            chk("incr8w BUSY Htrans", 32'(Htrans), 32'd1);
            chk("incr8w BUSY Haddr", Haddr, 32'h8400_0108);
            chk("incr8w BUSY wd_ready", 32'(wd_ready), 32'd0);
            chk("incr8w BUSY Hwdata", Hwdata, 32'd2);
        end
        for (int i = 2; i < 8; i++) begin
            cyc; wd_valid = 1'b1; wd_data = 32'(i + 1);
            @(negedge HCLK);
            chk("incr8w SEQ Htrans", 32'(Htrans), 32'd3);
            chk("incr8w SEQ Haddr", Haddr, 32'h8400_0100 + 32'(4 * i));
            chk("incr8w SEQ wd_ready", 32'(wd_ready), 32'd1);
            chk("incr8w Hwdata order", Hwdata, 32'(i));
            if (i == 2) chk("incr8w Hburst", 32'(Hburst), 32'd5);
        end
        cyc; wd_valid = 1'b0;
        @(negedge HCLK);
        chk("incr8w last Htrans", 32'(Htrans), 32'd0);
        chk("incr8w last Hwdata", Hwdata, 32'd8);
        cyc;
        @(negedge HCLK);
        chk("incr8w done", 32'(done), 32'd1);
        chk("incr8w err",  32'(err),  32'd0);
        cyc;
        chk("incr8w wd_ready pulses", 32'(n_wdr - wdr_base), 32'd8);

        // INCR4 read across the 1 KB boundary
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_03F8; cmd_burst = 2'b01;
        @(negedge HCLK); chk("kb cmd_ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            cyc; cmd_valid = 1'b0; Hrdata = 32'hD000_0000 + 32'(k);
            @(negedge HCLK);
            if (k <= 3) begin
                chk("kb Htrans", 32'(Htrans), (k == 0 || k == 2) ? 32'd2 : 32'd3);
                chk("kb Haddr", Haddr, 32'h8000_03F8 + 32'(4 * k));
            end else begin
                chk("kb idle Htrans", 32'(Htrans), 32'd0);
            end
            if (k >= 2) begin
                chk("kb rd_valid", 32'(rd_valid), 32'd1);
                chk("kb rd_data", rd_data, 32'hD000_0000 + 32'(k - 1));
            end else begin
                chk("kb no rd_valid", 32'(rd_valid), 32'd0);
            end
            chk("kb done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
        end

        // INCR8 read with ERROR on beat 2
        cyc; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_1000; cmd_burst = 2'b10;
        @(negedge HCLK); chk("rerr cmd_ready", 32'(cmd_ready), 32'd1);
        cyc; cmd_valid = 1'b0;
        @(negedge HCLK); chk("rerr beat1 Htrans", 32'(Htrans), 32'd2);
        cyc; Hrdata = 32'hB0B0_B0B0;
        @(negedge HCLK);
        chk("rerr beat2 Htrans", 32'(Htrans), 32'd3);
        chk("rerr beat2 rd_valid", 32'(rd_valid), 32'd0);
        cyc; Hreadyout = 1'b0; Hresp = 2'b01;
        @(negedge HCLK);
        chk("rerr beat3 Haddr", Haddr, 32'h8000_1008);
        chk("rerr beat1 rd_valid", 32'(rd_valid), 32'd1);
        chk("rerr beat1 rd_data", rd_data, 32'hB0B0_B0B0);
        cyc; Hreadyout = 1'b1; Hresp = 2'b01;
        @(negedge HCLK);
        chk("rerr Htrans idle", 32'(Htrans), 32'd0);
        chk("rerr no rd_valid", 32'(rd_valid), 32'd0);
        chk("rerr no early done", 32'(done), 32'd0);
        cyc; Hresp = 2'b00;
        @(negedge HCLK);
        chk("rerr done", 32'(done), 32'd1);
        chk("rerr err", 32'(err), 32'd1);
        chk("rerr errored beat rd_valid", 32'(rd_valid), 32'd0);
        cyc;
        @(negedge HCLK); chk("rerr err clears", 32'(err), 32'd0);

        // Reset during beat 3 of an INCR8 read, then a fresh SINGLE
        cyc; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_2000; cmd_burst = 2'b10;
        cyc; cmd_valid = 1'b0;
        cyc; Hrdata = 32'hC0C0_C0C0;
        cyc; HRESETn = 1'b0;
        @(negedge HCLK);
        chk("rst mid-burst Haddr", Haddr, 32'h8000_2008);
        chk("rst mid-burst rd_valid", 32'(rd_valid), 32'd1);
        cyc;
        @(negedge HCLK); chk_reset_vals("rst mid-burst");
        cyc; HRESETn = 1'b1; cmd_valid = 1'b1; cmd_addr = 32'h8000_0040; cmd_burst = 2'b00;
        @(negedge HCLK);
        chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post-rst no done", 32'(done), 32'd0);
        cyc; cmd_valid = 1'b0;
        @(negedge HCLK);
        chk("post-rst Htrans", 32'(Htrans), 32'd2);
        chk("post-rst Haddr", Haddr, 32'h8000_0040);
        cyc; Hrdata = 32'h1234_5678;
        @(negedge HCLK); chk("post-rst last Htrans", 32'(Htrans), 32'd0);
        cyc;
        @(negedge HCLK);
        chk("post-rst rd_data", rd_data, 32'h1234_5678);
        chk("post-rst done", 32'(done), 32'd1);
        chk("post-rst err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
